ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port image RAM (12-bit address, 8-bit data, 1-cycle registered read) between two requesters.
- Port 0 is the convolution processor core. Port 1 is the image loader / result dump engine.
- Round-robin with bounded burst ownership. Drives the RAM's w_en/r_en/address/data_in and returns read data to the owning port with a valid strobe.

Parameters:
- ADDR_W, 12, RAM address width
- DATA_W, 8, RAM data width
- MAX_BURST, 16, max consecutive beats an owner keeps the RAM while the other port is requesting (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  port 0 access request (one beat per granted cycle)
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_W  port 0 address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 beat accepted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_W  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- ram_w_en  out  1  to RAM w_en
- ram_r_en  out  1  to RAM r_en
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  DATA_W  to RAM data_in
- ram_rdata  in  DATA_W  from RAM data_out

Behaviour:
- Clock and reset: single clock domain, clk rising edge. rst_n asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_ptr=0 (port 0 preferred), beat_cnt=0.
  - All gnt, rvalid, ram_w_en and ram_r_en are 0.
  - ram_addr, ram_wdata, m0_rdata and m1_rdata are 0.
- States: IDLE, OWN0, OWN1.
- IDLE:
  - No RAM access; gnt=0.
  - At the edge, if exactly one req is high, go to OWN of that port.
  - If both are high, go to OWN[rr_ptr].
  - Otherwise stay in IDLE.
- OWNx:
  - mx_gnt = mx_req, combinational. Other port's gnt=0.
  - ram_addr/ram_wdata are muxed from port x.
  - ram_w_en = mx_req & mx_we; ram_r_en = mx_req & ~mx_we.
  - Each cycle with mx_gnt=1 is one beat; beat_cnt increments.
- Leaving OWNx, evaluated at the edge:
  - If mx_req=0: go to OWNy if my_req, else IDLE.
  - Else if beat_cnt==MAX_BURST-1 and my_req: go to OWNy.
  - Else stay in OWNx.
  - beat_cnt clears on any state change.
  - rr_ptr is set to the non-owning port on every exit from OWNx.
- Latency:
  - Request to first gnt is 1 cycle from IDLE.
  - An ownership switch costs no dead cycle: the new owner's gnt is high the cycle after the switch edge.
- Read return:
  - rvalid_x is registered and set at the edge where port x issued a granted read, so it is high in the following cycle.
  - mx_rdata = ram_rdata, qualified by mx_rvalid_x.
  - Back-to-back reads give back-to-back rvalid.
  - Writes never raise rvalid.
  - When ownership switches, rvalid for the old owner's last read still arrives on that old owner's port.
- Simultaneous events:
  - Both ports request from IDLE: rr_ptr decides.
  - Owner drops req while the other is requesting: handoff at that edge.
  - Owner at burst limit with the other idle: owner keeps the RAM, and beat_cnt saturates at MAX_BURST-1.
- Reset mid-operation:
  - Any in-flight read's rvalid is dropped; no gnt is issued in the reset cycle.
  - RAM contents are untouched.

Optional Feature:
- Macro: ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0 [15:0] and stat_gnt1 [15:0], counting granted beats per port.
  - Adds output stat_conflict [15:0], counting cycles where the non-owner req=1.
  - All three saturate at 16'hFFFF and clear on rst_n.
- Undefined: these ports and counters are absent; the arbitration behaviour is identical.

Test Plan:
- Single port:
  - Stimulus: port 0 only; write 8'hA5 @ 12'h10, then read @ 12'h10.
  - Response: m0_gnt 1 cycle after req; ram_w_en pulse with ram_addr=12'h010; m0_rvalid=1 with m0_rdata=8'hA5 the cycle after the read beat; m1 outputs stay 0.
- Simultaneous start:
  - Stimulus: both ports request from IDLE right after reset.
  - Response: port 0 owns first; after port 0 drops req, port 1 gets gnt the next cycle; rr_ptr=1 is then cleared back by port 1's exit.
- Burst limit:
  - Stimulus: MAX_BURST=4; port 1 holds req for 10 reads; port 0 requests continuously.
  - Response: exactly 4 m1_gnt beats, then 4 m0_gnt beats, alternating; no cycle with both gnt high; no idle gap at handoff.
- Lone owner past limit:
  - Stimulus: port 0 streams 20 reads @ 12'd910..12'd929; port 1 idle.
  - Response: 20 consecutive gnt beats; 20 rvalid pulses carrying RAM[910..929] in order.
- Reset mid-burst:
  - Stimulus: rst_n pulled low while port 1 owns the RAM and a read is in flight.
  - Response: gnt, rvalid and ram_r_en go 0 immediately (asynchronous); state is IDLE after release; the next request is served with 1-cycle latency.
- ARB_STATS_EN:
  - Stimulus: the burst-limit scenario with ARB_STATS_EN defined.
  - Response: stat_gnt0 and stat_gnt1 equal the beat counts; stat_conflict is non-zero; counters read 0 after reset.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// One requester's view of the shared image RAM: beat request/grant plus read return.
interface ram_port_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port RAM between two requesters.
// Optional per-port grant and conflict statistics are enabled with macro ARB_STATS_EN.
module ram_port_arbiter #(
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_port_arbiter_if.slave  m0,
   ram_port_arbiter_if.slave  m1,
   output logic               ram_w_en,
   output logic               ram_r_en,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic [DATA_W-1:0]  ram_wdata,
   input  logic [DATA_W-1:0]  ram_rdata
`ifdef ARB_STATS_EN
   ,
   output logic [15:0]        stat_gnt0,
   output logic [15:0]        stat_gnt1,
   output logic [15:0]        stat_conflict
`endif
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t           state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             rvalid0_q, rvalid0_d;
   logic             rvalid1_q, rvalid1_d;
   logic             at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= 1'b0;
         beat_cnt_q <= '0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      m0.gnt     = 1'b0;
      m1.gnt     = 1'b0;
      ram_w_en   = 1'b0;
      ram_r_en   = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      at_limit   = (beat_cnt_q == LAST_BEAT);

      unique case (state_q)
         IDLE: begin
            if (m0.req && m1.req) state_d = rr_ptr_q ? OWN1 : OWN0;
            else if (m0.req)      state_d = OWN0;
            else if (m1.req)      state_d = OWN1;
         end
         OWN0: begin
            m0.gnt    = m0.req;
            ram_addr  = m0.addr;
            ram_wdata = m0.wdata;
            ram_w_en  = m0.req & m0.we;
            ram_r_en  = m0.req & ~m0.we;
            if (!m0.req)                state_d = m1.req ? OWN1 : IDLE;
            else if (at_limit && m1.req) state_d = OWN1;
            if (state_d != OWN0) rr_ptr_d = 1'b1;
         end
         OWN1: begin
            m1.gnt    = m1.req;
            ram_addr  = m1.addr;
            ram_wdata = m1.wdata;
            ram_w_en  = m1.req & m1.we;
            ram_r_en  = m1.req & ~m1.we;
            if (!m1.req)                state_d = m0.req ? OWN0 : IDLE;
            else if (at_limit && m0.req) state_d = OWN0;
            if (state_d != OWN1) rr_ptr_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      // Count saturates so a lone owner can stream indefinitely without wrapping.
      if (state_d != state_q)                beat_cnt_d = '0;
      else if ((m0.gnt || m1.gnt) && !at_limit) beat_cnt_d = beat_cnt_q + 1'b1;
   end

   // Read valid follows the port that issued the read, even across an ownership switch.
   assign rvalid0_d = m0.gnt & ~m0.we;
   assign rvalid1_d = m1.gnt & ~m1.we;

   assign m0.rvalid = rvalid0_q;
   assign m1.rvalid = rvalid1_q;
   assign m0.rdata  = rvalid0_q ? ram_rdata : '0;
   assign m1.rdata  = rvalid1_q ? ram_rdata : '0;

`ifdef ARB_STATS_EN
   logic [15:0] stat_gnt0_q, stat_gnt1_q, stat_conflict_q;
   logic        conflict;

   assign conflict = ((state_q == OWN0) && m1.req) || ((state_q == OWN1) && m0.req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_gnt0_q     <= '0;
         stat_gnt1_q     <= '0;
         stat_conflict_q <= '0;
      end else begin
         if (m0.gnt && stat_gnt0_q != 16'hFFFF)     stat_gnt0_q     <= stat_gnt0_q + 16'd1;
         if (m1.gnt && stat_gnt1_q != 16'hFFFF)     stat_gnt1_q     <= stat_gnt1_q + 16'd1;
         if (conflict && stat_conflict_q != 16'hFFFF) stat_conflict_q <= stat_conflict_q + 16'd1;
      end
   end

   assign stat_gnt0     = stat_gnt0_q;
   assign stat_gnt1     = stat_gnt1_q;
   assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural registered-read RAM.
module tb_ram_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        ram_w_en, ram_r_en;
   logic [11:0] ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  mem [0:4095];
   int          errors;
   int          checks;
`ifdef ARB_STATS_EN
   logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

   ram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) m0_bus ();
   ram_port_arbiter_if #(.ADDR_W(12), .DATA_W(8)) m1_bus ();

   ram_port_arbiter #(.ADDR_W(12), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m0        (m0_bus),
      .m1        (m1_bus),
      .ram_w_en  (ram_w_en),
      .ram_r_en  (ram_r_en),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
`ifdef ARB_STATS_EN
      ,
      .stat_gnt0     (stat_gnt0),
      .stat_gnt1     (stat_gnt1),
      .stat_conflict (stat_conflict)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_w_en) mem[ram_addr] <= ram_wdata;
      if (ram_r_en) ram_rdata <= mem[ram_addr];
   end

   task automatic idle_inputs();
      m0_bus.req = 1'b0; m0_bus.we = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0;
      m1_bus.req = 1'b0; m1_bus.we = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      m0_bus.req = 1'b1;
      m1_bus.req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (m0_bus.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt0: got %b want 0", m0_bus.gnt); end
      checks++; if (m1_bus.gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt1: got %b want 0", m1_bus.gnt); end
      checks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {m0_bus.rvalid, m1_bus.rvalid}); end
      checks++; if ({ram_w_en, ram_r_en} !== 2'b00) begin errors++; $display("FAIL reset_ram_en: got %b want 00", {ram_w_en, ram_r_en}); end
      checks++; if (ram_addr !== 12'h000 || ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_bus: got addr=%h wdata=%h want 000/00", ram_addr, ram_wdata); end
      checks++; if (m0_bus.rdata !== 8'h00 || m1_bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", m0_bus.rdata, m1_bus.rdata); end
      checks++; if (dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL reset_rr_ptr: got %b want 0", dut.rr_ptr_q); end
`ifdef ARB_STATS_EN
      checks++; if ({stat_gnt0, stat_gnt1, stat_conflict} !== 48'd0) begin errors++; $display("FAIL reset_stats: got %h/%h/%h want 0", stat_gnt0, stat_gnt1, stat_conflict); end
`endif
      idle_inputs();
      rst_n = 1'b1;
      $display("reset: outputs quiet while rst_n low");
   endtask

   task automatic test_single_port();
      @(posedge clk); #1;
      m0_bus.req = 1'b1; m0_bus.we = 1'b1; m0_bus.addr = 12'h010; m0_bus.wdata = 8'hA5;
      @(negedge clk);
      checks++; if (m0_bus.gnt !== 1'b0) begin errors++; $display("FAIL single_latency: got gnt0=%b want 0", m0_bus.gnt); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (m0_bus.gnt !== 1'b1) begin errors++; $display("FAIL single_wr_gnt: got %b want 1", m0_bus.gnt); end
      checks++; if ({ram_w_en, ram_r_en} !== 2'b10) begin errors++; $display("FAIL single_wr_en: got w/r=%b want 10", {ram_w_en, ram_r_en}); end
      checks++; if (ram_addr !== 12'h010 || ram_wdata !== 8'hA5) begin errors++; $display("FAIL single_wr_bus: got %h/%h want 010/a5", ram_addr, ram_wdata); end
      $display("single: write a5 @ 010");
      @(posedge clk); #1;
      m0_bus.we = 1'b0;
      @(negedge clk);
      checks++; if (m0_bus.gnt !== 1'b1 || ram_r_en !== 1'b1) begin errors++; $display("FAIL single_rd_beat: got gnt=%b r_en=%b want 1/1", m0_bus.gnt, ram_r_en); end
      checks++; if (m0_bus.rvalid !== 1'b0) begin errors++; $display("FAIL single_rd_early: got rvalid0=%b want 0", m0_bus.rvalid); end
      @(posedge clk); #1;
      m0_bus.req = 1'b0;
      @(negedge clk);
      checks++; if (m0_bus.rvalid !== 1'b1 || m0_bus.rdata !== 8'hA5) begin errors++; $display("FAIL single_rd_data: got v=%b d=%h want 1/a5", m0_bus.rvalid, m0_bus.rdata); end
      checks++; if ({m1_bus.gnt, m1_bus.rvalid, m1_bus.rdata} !== 10'd0) begin errors++; $display("FAIL single_m1_quiet: got %b/%b/%h want 0", m1_bus.gnt, m1_bus.rvalid, m1_bus.rdata); end
      $display("single: read @ 010 -> %h", m0_bus.rdata);
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (m0_bus.rvalid !== 1'b0 || m0_bus.gnt !== 1'b0) begin errors++; $display("FAIL single_done: got v=%b g=%b want 0/0", m0_bus.rvalid, m0_bus.gnt); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      @(posedge clk); #1;
      m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 12'h001;
      m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 12'h002;
      @(negedge clk);
      checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b00) begin errors++; $display("FAIL sim_idle: got %b want 00", {m0_bus.gnt, m1_bus.gnt}); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin errors++; $display("FAIL sim_first_owner: got g0g1=%b want 10", {m0_bus.gnt, m1_bus.gnt}); end
      @(posedge clk); #1;
      m0_bus.req = 1'b0;
      @(negedge clk);
      checks++; if ({m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid} !== 3'b001) begin errors++; $display("FAIL sim_drop: got g0g1v0=%b want 001", {m0_bus.gnt, m1_bus.gnt, m0_bus.rvalid}); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({m1_bus.gnt, m0_bus.rvalid} !== 2'b10) begin errors++; $display("FAIL sim_handoff: got g1v0=%b want 10", {m1_bus.gnt, m0_bus.rvalid}); end
      checks++; if (dut.rr_ptr_q !== 1'b1) begin errors++; $display("FAIL sim_rr_set: got %b want 1", dut.rr_ptr_q); end
      @(posedge clk); #1;
      m1_bus.req = 1'b0;
      @(negedge clk);
      checks++; if ({m1_bus.gnt, m1_bus.rvalid} !== 2'b01) begin errors++; $display("FAIL sim_m1_rvalid: got g1v1=%b want 01", {m1_bus.gnt, m1_bus.rvalid}); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (dut.rr_ptr_q !== 1'b0) begin errors++; $display("FAIL sim_rr_clear: got %b want 0", dut.rr_ptr_q); end
      $display("simultaneous: port0 first, port1 after drop, rr_ptr back to 0");
   endtask

   task automatic test_burst_limit();
      logic [19:0] exp_g1;
      logic [19:0] exp_g0;
      exp_g1 = 20'h61E1E;
      exp_g0 = 20'h1E1E0;
      do_reset();
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         m1_bus.req = (c <= 18); m1_bus.we = 1'b0; m1_bus.addr = 12'(c);
         m0_bus.req = (c >= 1 && c <= 18); m0_bus.we = 1'b0; m0_bus.addr = 12'(100 + c);
         @(negedge clk);
         checks++; if ({m0_bus.gnt, m1_bus.gnt} !== {exp_g0[c], exp_g1[c]}) begin errors++; $display("FAIL burst_gnt c=%0d: got g0g1=%b want %b", c, {m0_bus.gnt, m1_bus.gnt}, {exp_g0[c], exp_g1[c]}); end
         checks++; if (ram_r_en !== (exp_g0[c] | exp_g1[c])) begin errors++; $display("FAIL burst_r_en c=%0d: got %b want %b", c, ram_r_en, exp_g0[c] | exp_g1[c]); end
         $display("burst: cycle %0d g0=%b g1=%b", c, m0_bus.gnt, m1_bus.gnt);
      end
`ifdef ARB_STATS_EN
      checks++; if (stat_gnt0 !== 16'd8 || stat_gnt1 !== 16'd10) begin errors++; $display("FAIL stats_gnt: got %0d/%0d want 8/10", stat_gnt0, stat_gnt1); end
      checks++; if (stat_conflict !== 16'd18) begin errors++; $display("FAIL stats_conflict: got %0d want 18", stat_conflict); end
`endif
      idle_inputs();
   endtask

   task automatic test_lone_owner();
      for (int i = 0; i < 20; i++) mem[910 + i] = 8'h30 + 8'(i);
      for (int c = 0; c < 22; c++) begin
         @(posedge clk); #1;
         m0_bus.req  = (c <= 20);
         m0_bus.we   = 1'b0;
         m0_bus.addr = (c == 0) ? 12'd910 : 12'(910 + c - 1);
         @(negedge clk);
         checks++; if (m0_bus.gnt !== (c >= 1 && c <= 20)) begin errors++; $display("FAIL lone_gnt c=%0d: got %b want %b", c, m0_bus.gnt, (c >= 1 && c <= 20)); end
         checks++; if (m0_bus.rvalid !== (c >= 2)) begin errors++; $display("FAIL lone_rvalid c=%0d: got %b want %b", c, m0_bus.rvalid, (c >= 2)); end
         if (c >= 2) begin
            checks++; if (m0_bus.rdata !== 8'h30 + 8'(c - 2)) begin errors++; $display("FAIL lone_rdata c=%0d: got %h want %h", c, m0_bus.rdata, 8'h30 + 8'(c - 2)); end
         end
         $display("lone: cycle %0d gnt=%b rvalid=%b rdata=%h", c, m0_bus.gnt, m0_bus.rvalid, m0_bus.rdata);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 12'd910;
      @(negedge clk);
      checks++; if (m1_bus.gnt !== 1'b0) begin errors++; $display("FAIL mid_latency: got %b want 0", m1_bus.gnt); end
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({m1_bus.gnt, m1_bus.rvalid} !== 2'b11 || m1_bus.rdata !== 8'h30) begin errors++; $display("FAIL mid_pre: got g1v1=%b d=%h want 11/30", {m1_bus.gnt, m1_bus.rvalid}, m1_bus.rdata); end
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({m1_bus.gnt, m1_bus.rvalid, ram_r_en} !== 3'b000) begin errors++; $display("FAIL mid_async: got g1/v1/r_en=%b want 000", {m1_bus.gnt, m1_bus.rvalid, ram_r_en}); end
      checks++; if (m1_bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %h want 00", m1_bus.rdata); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (m1_bus.gnt !== 1'b0) begin errors++; $display("FAIL mid_no_gnt: got %b want 0", m1_bus.gnt); end
`ifdef ARB_STATS_EN
      checks++; if ({stat_gnt0, stat_gnt1, stat_conflict} !== 48'd0) begin errors++; $display("FAIL mid_stats_clear: got %h/%h/%h want 0", stat_gnt0, stat_gnt1, stat_conflict); end
`endif
      idle_inputs();
      rst_n = 1'b1;
      $display("reset_mid: outputs dropped asynchronously");
      @(posedge clk); #1;
      m0_bus.req = 1'b1; m0_bus.we = 1'b0; m0_bus.addr = 12'd911;
      m1_bus.req = 1'b1; m1_bus.we = 1'b0; m1_bus.addr = 12'd912;
      @(negedge clk);
      checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b00) begin errors++; $display("FAIL mid_idle: got %b want 00", {m0_bus.gnt, m1_bus.gnt}); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({m0_bus.gnt, m1_bus.gnt} !== 2'b10) begin errors++; $display("FAIL mid_restart: got g0g1=%b want 10", {m0_bus.gnt, m1_bus.gnt}); end
      $display("reset_mid: restart served after 1 cycle by port 0");
      idle_inputs();
      repeat (2) @(posedge clk);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_port();
      test_simultaneous();
      test_burst_limit();
      test_lone_owner();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
